// File: rtl/branch_redirect_ctrl.sv
// branch_redirect_ctrl
// Execute-stage controller for the branch/jump target adder. Selects the
// adder source, resolves branch conditions from the ALU compare flags,
// issues a registered redirect to fetch, squashes the wrong-path slots
// that follow a redirect, flags bad control transfers and counts taken
// redirects.
module branch_redirect_ctrl #(
   parameter int unsigned SQUASH_DEPTH = 2,   // squashed execute slots, 1..7
   parameter int unsigned CNT_W        = 16   // taken-redirect counter width
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             valid_e,
   input  logic             stall_e,
   input  logic             branch_e,
   input  logic             jump_e,
   input  logic             jalr_e,
   input  logic [2:0]       funct3_e,
   input  logic             zero_e,
   input  logic             neg_e,
   input  logic             carry_e,
   input  logic             ovf_e,
   input  logic [31:0]      target_e,
   output logic             control_e_adder,
   output logic             kill_e,
   output logic             redirect_f,
   output logic [31:0]      redirect_pc_f,
   output logic             misalign_e,
   output logic             illegal_e,
   output logic [CNT_W-1:0] taken_cnt
);

   // Three bits cover the full 1..7 squash depth range.
   localparam int unsigned SQ_W = 3;
   localparam logic [SQ_W-1:0] SQ_LOAD = SQ_W'(SQUASH_DEPTH);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   // Squash slots remaining, redirect pulse/target and taken counter.
   logic [SQ_W-1:0]  squash_cnt_q, squash_cnt_d;
   logic             redirect_q, redirect_d;
   logic [31:0]      redirect_pc_q, redirect_pc_d;
   logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;

   // Execute-stage decode terms.
   logic             squashing;
   logic             live;
   logic             cond;
   logic             reserved_f3;
   logic             ctl_xfer;
   logic [31:0]      tgt;
   logic             take;

   // The adder source follows the instruction type alone; it is never
   // masked by squash or stall so the datapath settles the same way.
   assign control_e_adder = jump_e & jalr_e;

   // A slot is squashed while the counter is non-zero; only live slots
   // may redirect or raise exceptions.
   assign squashing = (squash_cnt_q != '0);
   assign kill_e    = valid_e & squashing;
   assign live      = valid_e & ~squashing;

   // Branch condition decode from the rs1-rs2 compare flags.
   always_comb begin
      cond        = 1'b0;
      reserved_f3 = 1'b0;
      case (funct3_e)
         3'b000:  cond = zero_e;               // BEQ
         3'b001:  cond = ~zero_e;              // BNE
         3'b100:  cond = neg_e ^ ovf_e;        // BLT
         3'b101:  cond = ~(neg_e ^ ovf_e);     // BGE
         3'b110:  cond = ~carry_e;             // BLTU (carry=1 means no borrow)
         3'b111:  cond = carry_e;              // BGEU
         default: reserved_f3 = 1'b1;          // 010/011 never taken
      endcase
   end

   // JALR clears bit 0 of the computed target; PC-relative targets pass.
   assign tgt = control_e_adder ? {target_e[31:1], 1'b0} : target_e;

   // A jump always transfers control and wins over a simultaneous branch.
   assign ctl_xfer = jump_e | (branch_e & cond);

   // Only a transfer that would actually happen can be misaligned.
   assign misalign_e = live & ctl_xfer & (tgt[1:0] != 2'b00);

   // Reserved branch encodings; a jump takes priority over the branch bit.
   assign illegal_e = live & branch_e & ~jump_e & reserved_f3;

   // A redirect is issued only from a live, non-stalled, aligned transfer.
   assign take = live & ~stall_e & ctl_xfer & ~misalign_e;

   // Next-state for redirect, squash counter and performance counter.
   always_comb begin
      squash_cnt_d  = squash_cnt_q;
      redirect_d    = redirect_q;
      redirect_pc_d = redirect_pc_q;
      taken_cnt_d   = taken_cnt_q;
      if (take) begin
         squash_cnt_d  = SQ_LOAD;
         redirect_d    = 1'b1;
         redirect_pc_d = tgt;
         if (taken_cnt_q != CNT_MAX) begin
            taken_cnt_d = taken_cnt_q + CNT_ONE;
         end
      end else if (!stall_e) begin
         // Redirect is a one-cycle pulse unless fetch is held by a stall.
         redirect_d = 1'b0;
         if (squashing) begin
            // Empty slots consume a squash count too.
            squash_cnt_d = squash_cnt_q - 1'b1;
         end
      end
   end

   // State registers; reset clears redirect and squash immediately.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         squash_cnt_q  <= '0;
         redirect_q    <= 1'b0;
         redirect_pc_q <= '0;
         taken_cnt_q   <= '0;
      end else begin
         squash_cnt_q  <= squash_cnt_d;
         redirect_q    <= redirect_d;
         redirect_pc_q <= redirect_pc_d;
         taken_cnt_q   <= taken_cnt_d;
      end
   end

   assign redirect_f    = redirect_q;
   assign redirect_pc_f = redirect_pc_q;
   assign taken_cnt     = taken_cnt_q;

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// tb_branch_redirect_ctrl
// Scoreboard bench: the stimulus process runs a behavioural model and
// queues the expected per-cycle outputs and expected redirects; a monitor
// pops and compares on every falling edge.
module tb_branch_redirect_ctrl;

   localparam int DEPTH = 2;
   localparam int CW    = 4;
   localparam int MAXC  = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          valid_e, stall_e, branch_e, jump_e, jalr_e;
   logic [2:0]    funct3_e;
   logic          zero_e, neg_e, carry_e, ovf_e;
   logic [31:0]   target_e;
   logic          control_e_adder, kill_e, redirect_f, misalign_e, illegal_e;
   logic [31:0]   redirect_pc_f;
   logic [CW-1:0] taken_cnt;

   branch_redirect_ctrl #(.SQUASH_DEPTH(DEPTH), .CNT_W(CW)) dut (
      .clk(clk), .reset_n(reset_n), .valid_e(valid_e), .stall_e(stall_e),
      .branch_e(branch_e), .jump_e(jump_e), .jalr_e(jalr_e),
      .funct3_e(funct3_e), .zero_e(zero_e), .neg_e(neg_e),
      .carry_e(carry_e), .ovf_e(ovf_e), .target_e(target_e),
      .control_e_adder(control_e_adder), .kill_e(kill_e),
      .redirect_f(redirect_f), .redirect_pc_f(redirect_pc_f),
      .misalign_e(misalign_e), .illegal_e(illegal_e), .taken_cnt(taken_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          adder, kill, mis, ill, redir;
      logic [31:0] pc;
      int          cnt;
   } snap_t;
   typedef struct {
      logic [31:0] pc;
      int          cnt;
   } red_t;

   snap_t exp_q[$];
   red_t  red_q[$];

   int n_cmp  = 0;
   int n_fail = 0;

   // Behavioural model state: slots still to be squashed, the redirect
   // presented to fetch, and the number of redirects issued (saturating).
   int          m_kill;
   bit          m_redir;
   logic [31:0] m_pc;
   int          m_cnt;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit cond_of(input logic [2:0] f3, input bit z, n, c, o);
      case (f3)
         3'd0: return z;
         3'd1: return !z;
         3'd4: return n != o;
         3'd5: return n == o;
         3'd6: return !c;
         3'd7: return c;
         default: return 1'b0;
      endcase
   endfunction

   task automatic model_reset();
      m_kill = 0; m_redir = 0; m_pc = '0; m_cnt = 0;
   endtask

   // One execute slot: drive inputs, queue expectations, advance the model.
   task automatic cyc(input bit v, s, b, j, jr, input logic [2:0] f3,
                      input bit z, n, c, o, input logic [31:0] t);
      snap_t       sn;
      red_t        rd;
      bit          sq, live, ctl, mis, ill, take, adder;
      logic [31:0] tg;
      valid_e = v; stall_e = s; branch_e = b; jump_e = j; jalr_e = jr;
      funct3_e = f3; zero_e = z; neg_e = n; carry_e = c; ovf_e = o; target_e = t;
      sq    = m_kill > 0;
      live  = v && !sq;
      adder = j && jr;
      tg    = adder ? (t & 32'hFFFF_FFFE) : t;
      ctl   = j || (b && cond_of(f3, z, n, c, o));
      mis   = live && ctl && (tg % 4 != 0);
      ill   = live && b && !j && (f3 == 3'd2 || f3 == 3'd3);
      take  = live && !s && ctl && !mis;
      sn.adder = adder; sn.kill = v && sq; sn.mis = mis; sn.ill = ill;
      sn.redir = m_redir; sn.pc = m_pc; sn.cnt = m_cnt;
      exp_q.push_back(sn);
      $display("slot v=%0d s=%0d b=%0d j=%0d jr=%0d f3=%0d tgt=%h live=%0d take=%0d",
               v, s, b, j, jr, f3, t, live, take);
      @(posedge clk);
      #1;
      if (take) begin
         m_redir = 1; m_pc = tg;
         if (m_cnt < MAXC) m_cnt++;
         m_kill = DEPTH;
         rd.pc = tg; rd.cnt = m_cnt;
         red_q.push_back(rd);
      end else if (!s) begin
         m_redir = 0;
         if (sq) m_kill--;
      end
   endtask

   task automatic idle(input bit v);
      cyc(v, 0, 0, 0, 0, 3'd0, 0, 0, 0, 0, 32'h0);
   endtask

   // Monitor: compare the queued snapshot every cycle and match each new
   // redirect pulse against the expected redirect queue.
   bit stall_prev = 0;
   initial begin
      snap_t sn;
      red_t  rd;
      forever begin
         @(negedge clk);
         if (reset_n) begin
            if (exp_q.size() > 0) begin
               sn = exp_q.pop_front();
               chk("adder_sel",   {31'd0, control_e_adder}, {31'd0, sn.adder});
               chk("kill_e",      {31'd0, kill_e},          {31'd0, sn.kill});
               chk("misalign_e",  {31'd0, misalign_e},      {31'd0, sn.mis});
               chk("illegal_e",   {31'd0, illegal_e},       {31'd0, sn.ill});
               chk("redirect_f",  {31'd0, redirect_f},      {31'd0, sn.redir});
               chk("redirect_pc", redirect_pc_f,            sn.pc);
               chk("taken_cnt",   32'(taken_cnt),           32'(sn.cnt));
            end
            if (redirect_f && !stall_prev) begin
               if (red_q.size() == 0) begin
                  n_cmp++; n_fail++;
                  $display("FAIL unexpected_redirect: got pc %h expected none", redirect_pc_f);
               end else begin
                  rd = red_q.pop_front();
                  chk("redir_ev_pc",  redirect_pc_f,    rd.pc);
                  chk("redir_ev_cnt", 32'(taken_cnt),   32'(rd.cnt));
               end
            end
         end
         stall_prev = reset_n && stall_e;
      end
   end

   // Watchdog so the run always ends.
   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      reset_n = 0;
      valid_e = 1; stall_e = 0; branch_e = 0; jump_e = 0; jalr_e = 0;
      funct3_e = 0; zero_e = 0; neg_e = 0; carry_e = 0; ovf_e = 0; target_e = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_redirect_f",  {31'd0, redirect_f}, 32'd0);
      chk("rst_redirect_pc", redirect_pc_f,       32'd0);
      chk("rst_taken_cnt",   32'(taken_cnt),      32'd0);
      chk("rst_kill_e",      {31'd0, kill_e},     32'd0);
      reset_n = 1;

      // BEQ taken, then two killed slots and a live one.
      cyc(1, 0, 1, 0, 0, 3'b000, 1, 0, 0, 0, 32'h0000_0100);
      idle(1); idle(1); idle(1);
      // JALR with odd target.
      cyc(1, 0, 0, 1, 1, 3'b000, 0, 0, 0, 0, 32'h0000_2005);
      idle(1); idle(1); idle(1);
      // JAL to misaligned target: no redirect.
      cyc(1, 0, 0, 1, 0, 3'b000, 0, 0, 0, 0, 32'h0000_1002);
      idle(1);
      // Signed vs unsigned compare: BLT taken, BLTU not, reserved illegal.
      cyc(1, 0, 1, 0, 0, 3'b100, 0, 1, 1, 0, 32'h0000_0400);
      idle(1); idle(0);
      cyc(1, 0, 1, 0, 0, 3'b110, 0, 1, 1, 0, 32'h0000_0800);
      cyc(1, 0, 1, 0, 0, 3'b010, 0, 1, 1, 0, 32'h0000_0800);
      idle(1);
      // Take held off by a three-cycle stall, then exactly one redirect.
      repeat (3) cyc(1, 1, 1, 0, 0, 3'b001, 0, 0, 0, 0, 32'h0000_0C00);
      cyc(1, 0, 1, 0, 0, 3'b001, 0, 0, 0, 0, 32'h0000_0C00);
      // Stall during squash: counter holds across stalled slots.
      cyc(1, 1, 0, 0, 0, 3'd0, 0, 0, 0, 0, 32'h0);
      cyc(1, 1, 0, 0, 0, 3'd0, 0, 0, 0, 0, 32'h0);
      idle(1); idle(1); idle(1);
      // Asynchronous reset mid-squash.
      cyc(1, 0, 0, 1, 0, 3'd0, 0, 0, 0, 0, 32'h0000_1000);
      idle(1);
      valid_e = 1; stall_e = 0; jump_e = 0; branch_e = 0;
      #2;
      reset_n = 0;
      #1;
      chk("async_redirect_f",  {31'd0, redirect_f}, 32'd0);
      chk("async_redirect_pc", redirect_pc_f,       32'd0);
      chk("async_taken_cnt",   32'(taken_cnt),      32'd0);
      chk("async_kill_e",      {31'd0, kill_e},     32'd0);
      exp_q.delete(); red_q.delete();
      model_reset();
      @(posedge clk);
      #1;
      reset_n = 1;
      // First post-reset instruction is live.
      cyc(1, 0, 1, 0, 0, 3'b111, 0, 0, 1, 0, 32'h0000_0040);
      idle(1); idle(1); idle(1);

      // Randomised traffic.
      for (int i = 0; i < 3000; i++) begin
         int op;
         bit v, s, b, j, jr;
         op = $urandom_range(0, 4);
         v  = ($urandom_range(0, 9) < 8);
         s  = ($urandom_range(0, 3) == 0);
         b  = (op == 1) || (op == 4);
         j  = (op == 2) || (op == 3) || (op == 4);
         jr = (op == 3) || ((op == 4) && $urandom_range(0, 1) == 1);
         cyc(v, s, b, j, jr, 3'($urandom_range(0, 7)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             ($urandom_range(0, 1) == 1) ? ($urandom & 32'hFFFF_FFFC) : $urandom);
      end
      idle(0); idle(0); idle(0);

      // Counter saturation from a fresh reset.
      reset_n = 0;
      #1;
      exp_q.delete(); red_q.delete();
      model_reset();
      @(posedge clk);
      #1;
      reset_n = 1;
      for (int i = 0; i < MAXC + 3; i++) begin
         cyc(1, 0, 1, 0, 0, 3'b000, 1, 0, 0, 0, 32'(i * 16));
         idle(1); idle(1);
      end
      idle(1); idle(1);
      chk("sat_taken_cnt", 32'(taken_cnt), 32'(MAXC));
      @(negedge clk);
      chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
      chk("red_q_drained", 32'(red_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/branch_redirect_ctrl.md
Name: branch_redirect_ctrl

Overview:
- Execute-stage controller for the branch/jump target adder.
- Drives the adder source select: PC for branches and JAL, rs1 for JALR.
- Resolves branch conditions from the ALU compare flags and issues a registered redirect to fetch.
- Squashes the wrong-path instructions that follow a redirect, flags misaligned or illegal control transfers, and counts taken redirects for performance monitoring.

Parameters:
- SQUASH_DEPTH, 2, number of non-stalled execute slots squashed after a redirect (1..7).
- CNT_W, 16, width of the saturating taken-redirect counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- valid_e  input  1  execute stage holds a real instruction.
- stall_e  input  1  execute stage frozen this cycle.
- branch_e  input  1  instruction is a conditional branch.
- jump_e  input  1  instruction is JAL or JALR.
- jalr_e  input  1  instruction is JALR (valid only with jump_e).
- funct3_e  input  3  branch condition code.
- zero_e, neg_e, carry_e, ovf_e  input  1 each  ALU flags of rs1-rs2; carry_e=1 means no borrow.
- target_e  input  32  adder result.
- control_e_adder  output  1  adder source select: 0=PC, 1=rs1.
- kill_e  output  1  current execute instruction is squashed.
- redirect_f  output  1  registered redirect request to fetch.
- redirect_pc_f  output  32  registered redirect target.
- misalign_e  output  1  taken target not word aligned.
- illegal_e  output  1  branch with reserved funct3.
- taken_cnt  output  CNT_W  saturating count of issued redirects.

Behaviour:
- Reset (async, reset_n=0): redirect_f=0, redirect_pc_f=0, squash counter=0, taken_cnt=0. Combinational outputs follow their inputs.
- control_e_adder = jump_e & jalr_e. Purely combinational, never masked.
- squashing = (squash counter != 0).
- kill_e = valid_e & squashing.
- live = valid_e & ~squashing.
- Branch condition by funct3:
  - 000 BEQ: zero_e
  - 001 BNE: ~zero_e
  - 100 BLT: neg_e^ovf_e
  - 101 BGE: ~(neg_e^ovf_e)
  - 110 BLTU: ~carry_e
  - 111 BGEU: carry_e
  - 010/011: not taken; illegal_e = live & branch_e.
- Target tgt = target_e with bit0 forced to 0 when control_e_adder=1; otherwise target_e unchanged.
- misalign_e = live & (jump_e | taken branch) & (tgt[1:0] != 0).
- take = live & ~stall_e & (jump_e | (branch_e & cond)) & ~misalign_e.
- jump_e has priority over branch_e if both are asserted.
- Redirect latency is 1 cycle:
  - On the edge after take, redirect_f=1 and redirect_pc_f=tgt.
  - Otherwise redirect_f=0 and redirect_pc_f holds its last value.
  - redirect_f is a single-cycle pulse.
- Squash counter:
  - On take, load SQUASH_DEPTH.
  - Else if squashing & ~stall_e, decrement by 1.
  - Else hold.
  - While stall_e=1 the counter, redirect_f and taken_cnt all hold; redirect_f holds only if already 1.
- A taken condition occurring in a squash slot is ignored: kill_e=1, no redirect, no count. Squashed instructions never assert misalign_e or illegal_e.
- A slot with valid_e=0 during squashing still consumes a squash count, provided it is not stalled.
- taken_cnt increments on each take and saturates at all-ones.
- Reset mid-squash or mid-redirect clears everything immediately. The first post-reset instruction is live.

Test Plan:
- BEQ taken: valid_e=1, branch_e=1, funct3=000, zero_e=1, target_e=0x0000_0100 -> next cycle redirect_f=1, redirect_pc_f=0x100, taken_cnt=1; the next 2 valid slots have kill_e=1; the third has kill_e=0.
- JALR with odd target: jump_e=jalr_e=1, target_e=0x0000_2005 -> control_e_adder=1, redirect_pc_f=0x2004.
- JAL with target_e=0x1002 -> misalign_e=1, no redirect, taken_cnt unchanged.
- Signed vs unsigned compare: neg_e=1, ovf_e=0, carry_e=1. BLT (100) -> taken; BLTU (110) -> not taken, redirect_f stays 0. funct3=010 -> illegal_e=1.
- Stall interaction:
  - Take pending with stall_e=1 for 3 cycles -> no redirect until stall_e falls, then exactly one redirect.
  - Stall during squash -> counter holds; kill_e stays 1 until 2 non-stalled slots pass.
- Reset: pull reset_n low mid-squash asynchronously -> all outputs clear without a clock edge. Separately, preload taken_cnt near 0xFFFF and issue 3 takes -> taken_cnt saturates at 0xFFFF.
